// File: rtl/tsip_packet_tx.sv
// TSIP packet transmitter: frames DLE, ID, DLE-stuffed payload, DLE, ETX and shifts it out as UART 8N1.
// Define TSIP_TX_ODD_PARITY_EN to insert an odd parity bit after data bit 7 (8O1).
`timescale 1ns/1ps
module tsip_packet_tx #(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_id,
  input  logic       i_no_payload,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  input  logic       i_data_last,
  output logic       o_data_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_tx
);

  localparam logic [7:0] DLE = 8'h10;
  localparam logic [7:0] ETX = 8'h03;
`ifdef TSIP_TX_ODD_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd10;
`else
  localparam logic [3:0] LAST_BIT = 4'd9;
`endif
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_ID,
    S_PAY,
    S_EOF_DLE,
    S_EOF_ETX
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  id_r;
  logic        no_pay_r;
  logic        stuff_pend, stuff_pend_nxt;
  logic        last_pend, last_pend_nxt;
  logic        ser_active;
  logic [7:0]  shreg;
  logic [3:0]  bit_cnt;
  logic [15:0] baud_cnt;
  logic        tx_r;
  logic        done_r, done_nxt;
  logic        byte_end, ser_free, accept, load;
  logic [7:0]  load_byte;

  // Line level for bit slot idx of a byte: start, data LSB first, optional parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic v;
    v = 1'b1;
    if (idx == 4'd0)
      v = 1'b0;
    else if (idx <= 4'd8)
      v = b[3'(idx - 4'd1)];
`ifdef TSIP_TX_ODD_PARITY_EN
    else if (idx == 4'd9)
      v = ~^b;
`endif
    return v;
  endfunction

  assign byte_end = ser_active && (bit_cnt == LAST_BIT) && (baud_cnt == BAUD_MAX);
  assign ser_free = !ser_active || byte_end;

  // A payload byte may be taken on the last cycle of the previous byte so frames stay gapless.
  assign o_data_ready = ((state == S_PAY) || ((state == S_ID) && !no_pay_r)) &&
                        ser_free && !stuff_pend && !last_pend;
  assign accept       = o_data_ready && i_data_valid;
  assign o_busy       = (state != S_IDLE);
  assign o_done       = done_r;
  assign o_tx         = tx_r;

  always_comb begin
    state_nxt      = state;
    load           = 1'b0;
    load_byte      = DLE;
    stuff_pend_nxt = stuff_pend;
    last_pend_nxt  = last_pend;
    done_nxt       = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          load      = 1'b1;
          state_nxt = S_SOF;
        end
      end
      S_SOF: begin
        if (byte_end) begin
          load           = 1'b1;
          load_byte      = id_r;
          stuff_pend_nxt = (id_r == DLE);
          state_nxt      = S_ID;
        end
      end
      S_ID, S_PAY: begin
        if (accept) begin
          load           = 1'b1;
          load_byte      = i_data;
          stuff_pend_nxt = (i_data == DLE);
          last_pend_nxt  = i_data_last;
          state_nxt      = S_PAY;
        end else if (byte_end) begin
          if (stuff_pend) begin
            load           = 1'b1;
            stuff_pend_nxt = 1'b0;
          end else if (last_pend || ((state == S_ID) && no_pay_r)) begin
            load          = 1'b1;
            last_pend_nxt = 1'b0;
            state_nxt     = S_EOF_DLE;
          end else begin
            state_nxt = S_PAY;
          end
        end
      end
      S_EOF_DLE: begin
        if (byte_end) begin
          load      = 1'b1;
          load_byte = ETX;
          state_nxt = S_EOF_ETX;
        end
      end
      S_EOF_ETX: begin
        if (byte_end) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      id_r       <= 8'h00;
      no_pay_r   <= 1'b0;
      stuff_pend <= 1'b0;
      last_pend  <= 1'b0;
      done_r     <= 1'b0;
      ser_active <= 1'b0;
      shreg      <= 8'h00;
      bit_cnt    <= 4'd0;
      baud_cnt   <= 16'd0;
      tx_r       <= 1'b1;
    end else begin
      stuff_pend <= stuff_pend_nxt;
      last_pend  <= last_pend_nxt;
      done_r     <= done_nxt;
      if ((state == S_IDLE) && i_start) begin
        id_r     <= i_id;
        no_pay_r <= i_no_payload;
      end
      // Serializer: a load always wins so the next start bit directly follows the stop bit.
      if (load) begin
        ser_active <= 1'b1;
        shreg      <= load_byte;
        bit_cnt    <= 4'd0;
        baud_cnt   <= 16'd0;
        tx_r       <= 1'b0;
      end else if (byte_end) begin
        ser_active <= 1'b0;
        bit_cnt    <= 4'd0;
        baud_cnt   <= 16'd0;
        tx_r       <= 1'b1;
      end else if (ser_active) begin
        if (baud_cnt == BAUD_MAX) begin
          baud_cnt <= 16'd0;
          bit_cnt  <= bit_cnt + 4'd1;
          tx_r     <= frame_bit(shreg, bit_cnt + 4'd1);
        end else begin
          baud_cnt <= baud_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tsip_packet_tx.sv
// Self-checking bench for tsip_packet_tx: frame reference model, exact line waveform checks and a UART line decoder.
`timescale 1ns/1ps
module tb_tsip_packet_tx;

  localparam int C = 4;
`ifdef TSIP_TX_ODD_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int BYTE_CYC = BITS * C;

  typedef byte unsigned bq_t[$];

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [7:0] i_id;
  logic       i_no_payload;
  logic [7:0] i_data;
  logic       i_data_valid;
  logic       i_data_last;
  logic       o_data_ready;
  logic       o_busy;
  logic       o_done;
  logic       o_tx;

  int n_cmp = 0;
  int n_bad = 0;
  byte unsigned rx_q[$];
  int frame_err = 0;
  bit cap[$];

  tsip_packet_tx #(.CLKS_PER_BIT(C)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_id         (i_id),
    .i_no_payload (i_no_payload),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_data_last  (i_data_last),
    .o_data_ready (o_data_ready),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_tx         (o_tx)
  );

  always #5 clk = ~clk;

  // Reference framing: DLE, ID (stuffed), payload with every DLE doubled, DLE, ETX.
  function automatic bq_t frame_model(input byte unsigned id, input bit nopay, input bq_t pay);
    bq_t f;
    f.push_back(8'h10);
    f.push_back(id);
    if (id == 8'h10) f.push_back(8'h10);
    if (!nopay) begin
      foreach (pay[i]) begin
        f.push_back(pay[i]);
        if (pay[i] == 8'h10) f.push_back(8'h10);
      end
    end
    f.push_back(8'h10);
    f.push_back(8'h03);
    return f;
  endfunction

  // UART decoder: samples each bit mid-way, checks start/parity/stop levels.
  initial begin : uart_mon
    logic [7:0] b;
    logic ok;
    forever begin
      @(negedge clk);
      if (i_rst === 1'b1 && o_tx === 1'b0) begin
        repeat (C / 2) @(negedge clk);
        ok = (o_tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = o_tx;
        end
`ifdef TSIP_TX_ODD_PARITY_EN
        repeat (C) @(negedge clk);
        ok = ok && (o_tx === (($countones(b) % 2) == 0));
`endif
        repeat (C) @(negedge clk);
        ok = ok && (o_tx === 1'b1);
        rx_q.push_back(b);
        if (!ok) frame_err++;
        repeat (C - C / 2 - 1) @(negedge clk);
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    i_rst = 1'b0;
    i_start = 1'b1;
    i_id = 8'h8E;
    i_no_payload = 1'b0;
    i_data = 8'h00;
    i_data_valid = 1'b0;
    i_data_last = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b required 1", o_tx); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", o_busy); end
    n_cmp++; if (o_data_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b required 0", o_data_ready); end
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b required 0", o_done); end
    i_start = 1'b0;
    @(negedge clk);
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_release_idle: got tx=%b busy=%b required tx=1 busy=0", o_tx, o_busy);
    end
  endtask

  // Payload offered without stalls: the line must match the model cycle for cycle.
  task automatic run_exact(input string name, input byte unsigned id, input bit nopay, input bq_t pay, input bit poke);
    bq_t fr;
    bit lv[$];
    int total, idx, tx_bad, busy_bad, first_k, idle_bad;
    bit acc_prev;
    logic first_got, first_exp;
    fr = frame_model(id, nopay, pay);
    foreach (fr[j]) begin
      lv.push_back(1'b0);
      for (int i = 0; i < 8; i++) lv.push_back(fr[j][i]);
`ifdef TSIP_TX_ODD_PARITY_EN
      lv.push_back(($countones(fr[j]) % 2) == 0);
`endif
      lv.push_back(1'b1);
    end
    total = lv.size() * C;
    cap.delete();
    tx_bad = 0; busy_bad = 0; idle_bad = 0; first_k = -1; idx = 0; acc_prev = 1'b0;
    first_got = 1'b0; first_exp = 1'b0;
    i_data_valid = 1'b0;
    @(negedge clk);
    i_start = 1'b1; i_id = id; i_no_payload = nopay;
    if (!nopay) begin
      i_data_valid = 1'b1; i_data = pay[0]; i_data_last = (pay.size() == 1);
    end
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      i_start = 1'b0; i_id = 8'($urandom); i_no_payload = 1'($urandom);
      if (poke && (k == 3 || k == total)) begin i_start = 1'b1; i_id = 8'hAA; end
      if (acc_prev) begin
        idx++;
        if (idx < pay.size()) begin
          i_data = pay[idx]; i_data_last = (idx == pay.size() - 1);
        end else begin
          i_data_valid = 1'b0; i_data = 8'($urandom); i_data_last = 1'($urandom);
        end
      end
      acc_prev = o_data_ready && i_data_valid;
      if (k <= total) begin
        cap.push_back(o_tx);
        if (o_tx !== lv[(k - 1) / C]) begin
          tx_bad++;
          if (first_k < 0) begin first_k = k; first_got = o_tx; first_exp = lv[(k - 1) / C]; end
        end
        if (o_busy !== 1'b1 || o_done !== 1'b0) busy_bad++;
      end
    end
    i_start = 1'b0;
    n_cmp++;
    if (tx_bad !== 0) begin
      n_bad++;
      $display("FAIL %s tx_wave: %0d bad cycles, first at cycle %0d got %b required %b", name, tx_bad, first_k, first_got, first_exp);
    end
    n_cmp++;
    if (busy_bad !== 0) begin n_bad++; $display("FAIL %s busy_during_frame: %0d cycles not busy, required 0", name, busy_bad); end
    n_cmp++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      n_bad++; $display("FAIL %s done_timing: at cycle %0d got done=%b busy=%b required done=1 busy=0", name, total + 1, o_done, o_busy);
    end
    for (int k = 0; k < 3 * BYTE_CYC; k++) begin
      @(negedge clk);
      if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) idle_bad++;
    end
    n_cmp++;
    if (idle_bad !== 0) begin n_bad++; $display("FAIL %s idle_after_done: %0d active cycles, required 0", name, idle_bad); end
  endtask

  // Payload offered with random valid gaps: bytes checked through the decoder.
  task automatic run_stream(input string name, input byte unsigned id, input bit nopay, input bq_t pay, input int smin, input int smax);
    bq_t fr;
    int idx, stall, gap, exp_gap, gap_bad, busy_bad, idle_bad, k, byte_bad;
    bit acc_prev, meas, fin;
    fr = frame_model(id, nopay, pay);
    rx_q.delete(); frame_err = 0;
    idx = 0; gap = 0; exp_gap = 0; gap_bad = 0; busy_bad = 0; idle_bad = 0; k = 0; byte_bad = 0;
    acc_prev = 1'b0; meas = 1'b0; fin = 1'b0;
    stall = $urandom_range(smax, smin);
    i_data_valid = 1'b0;
    @(negedge clk);
    i_start = 1'b1; i_id = id; i_no_payload = nopay;
    while (!fin && k < 20000) begin
      @(negedge clk);
      k++;
      i_start = 1'b0; i_id = 8'($urandom); i_no_payload = 1'($urandom);
      if (acc_prev) begin
        if (idx != pay.size() - 1) begin
          meas = 1'b1; gap = 0; exp_gap = BYTE_CYC * ((pay[idx] == 8'h10) ? 2 : 1) - 1;
        end
        idx++;
        i_data_valid = 1'b0; i_data = 8'($urandom); i_data_last = 1'($urandom);
        stall = $urandom_range(smax, smin);
      end
      if (!nopay && !i_data_valid && idx < pay.size()) begin
        if (stall == 0) begin
          i_data_valid = 1'b1; i_data = pay[idx]; i_data_last = (idx == pay.size() - 1);
        end else begin
          stall--;
        end
      end
      acc_prev = o_data_ready && i_data_valid;
      if (meas) begin
        if (o_data_ready === 1'b1) begin
          if (gap !== exp_gap) gap_bad++;
          meas = 1'b0;
        end else begin
          gap++;
        end
      end
      if (o_data_ready === 1'b1 && o_tx !== 1'b1) idle_bad++;
      if (o_done === 1'b1) begin
        fin = 1'b1;
        if (o_busy !== 1'b0) busy_bad++;
      end else if (o_busy !== 1'b1) begin
        busy_bad++;
      end
    end
    n_cmp++;
    if (!fin) begin n_bad++; $display("FAIL %s done_seen: got no done in %0d cycles, required one pulse", name, k); end
    @(negedge clk);
    n_cmp++;
    if (o_done !== 1'b0) begin n_bad++; $display("FAIL %s done_single: got done=%b one cycle later, required 0", name, o_done); end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rx_q.size() !== fr.size()) begin
      n_bad++; $display("FAIL %s byte_count: got %0d bytes required %0d", name, rx_q.size(), fr.size());
    end else begin
      foreach (fr[i]) if (rx_q[i] !== fr[i]) byte_bad++;
      n_cmp++;
      if (byte_bad !== 0) begin n_bad++; $display("FAIL %s byte_values: %0d bytes differ, first got %h required %h", name, byte_bad, rx_q[0], fr[0]); end
    end
    n_cmp++;
    if (frame_err !== 0) begin n_bad++; $display("FAIL %s uart_framing: got %0d framing errors required 0", name, frame_err); end
    n_cmp++;
    if (gap_bad !== 0) begin n_bad++; $display("FAIL %s ready_hold: %0d ready-low intervals wrong, required 0", name, gap_bad); end
    n_cmp++;
    if (busy_bad !== 0) begin n_bad++; $display("FAIL %s busy_stream: %0d bad cycles required 0", name, busy_bad); end
    n_cmp++;
    if (idle_bad !== 0) begin n_bad++; $display("FAIL %s ready_line_idle: %0d cycles tx low while ready, required 0", name, idle_bad); end
  endtask

  task automatic test_known_packets();
    bq_t p, e;
    p.push_back(8'h10); p.push_back(8'h03); p.push_back(8'h55);
    run_exact("pkt_8e", 8'h8E, 1'b0, p, 1'b0);
    run_stream("pkt_8e_stream", 8'h8E, 1'b0, p, 0, 3);
    run_exact("noload_1c", 8'h1C, 1'b1, e, 1'b0);
    p.delete(); p.push_back(8'h20);
    run_exact("id_stuffed", 8'h10, 1'b0, p, 1'b1);
  endtask

  task automatic test_stall();
    bq_t p;
    p.push_back(8'h10); p.push_back(8'h5A); p.push_back(8'h10);
    run_stream("stall_500", 8'h47, 1'b0, p, 500, 500);
  endtask

  task automatic test_random();
    bq_t p;
    byte unsigned id;
    bit nopay;
    int len, r;
    for (int n = 0; n < 12; n++) begin
      p.delete();
      id = ($urandom_range(3, 0) == 0) ? 8'h10 : 8'($urandom);
      nopay = ($urandom_range(4, 0) == 0);
      len = nopay ? 0 : $urandom_range(6, 1);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(5, 0);
        p.push_back((r < 2) ? 8'h10 : (r == 2) ? 8'h03 : 8'($urandom));
      end
      if (n % 2 == 0) run_exact("rand_exact", id, nopay, p, 1'($urandom));
      else            run_stream("rand_stream", id, nopay, p, 0, 7);
    end
  endtask

  task automatic test_reset_mid();
    bq_t p;
    int act;
    @(negedge clk);
    i_start = 1'b1; i_id = 8'h8E; i_no_payload = 1'b0;
    i_data_valid = 1'b1; i_data = 8'h10; i_data_last = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    repeat (2 * BYTE_CYC + C + 2) @(negedge clk);
    n_cmp++;
    if (o_busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre_busy: got %b required 1", o_busy); end
    @(posedge clk);
    #2 i_rst = 1'b0;
    #1;
    n_cmp++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_data_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_abort: got tx=%b busy=%b ready=%b required 1 0 0", o_tx, o_busy, o_data_ready);
    end
    i_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    act = 0;
    for (int k = 0; k < BYTE_CYC + 2 * C; k++) begin
      @(negedge clk);
      if (o_tx !== 1'b1 || o_busy !== 1'b0) act++;
    end
    n_cmp++;
    if (act !== 0) begin n_bad++; $display("FAIL rst_mid_no_resume: %0d active cycles after release, required 0", act); end
    rx_q.delete(); frame_err = 0;
    p.push_back(8'h03); p.push_back(8'h10);
    run_exact("rst_fresh", 8'h8E, 1'b0, p, 1'b0);
  endtask

`ifdef TSIP_TX_ODD_PARITY_EN
  task automatic test_parity();
    bq_t e;
    run_exact("parity_frame", 8'h8E, 1'b1, e, 1'b1);
    n_cmp++;
    if (cap[BYTE_CYC + 9 * C + C / 2] !== 1'b1) begin
      n_bad++; $display("FAIL parity_8e: got %b required 1", cap[BYTE_CYC + 9 * C + C / 2]);
    end
    n_cmp++;
    if (cap[3 * BYTE_CYC + 9 * C + C / 2] !== 1'b1) begin
      n_bad++; $display("FAIL parity_03: got %b required 1", cap[3 * BYTE_CYC + 9 * C + C / 2]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_known_packets();
    test_stall();
    test_random();
    test_reset_mid();
`ifdef TSIP_TX_ODD_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
